mfe_scan_ctrl: RTL and testbench
================================

// Module: mfe_scan_ctrl
// PURPOSE
//  Raster-scan sequencer for the 3x3 median filter engine. Walks every pixel of a 128x128 image
//  and issues the 9 neighbour reads for each one, flagging padded (out-of-image) taps. It hands
//  each tap to the sort datapath, then writes that datapath's median to result memory.
//  It sits between the host ready/busy handshake, image ROM, sort datapath and result RAM.
// PARAMETERS
//  COL_W   7   column index width (image width = 2**COL_W)
//  ROW_W   7   row index width (image height = 2**ROW_W)
//  ADDR_W  14  memory address width, = ROW_W+COL_W
//  DATA_W  8   pixel width
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  reset      in   1       synchronous, active-high
//  ready      in   1       host start request, sampled only in IDLE
//  busy       out  1       high from first FETCH cycle until FINISH
//  iaddr      out  ADDR_W  image ROM read address; ROM returns idata one cycle later
//  tap_vld    out  1       idata/pad valid for the sorter this cycle (1 cycle after iaddr)
//  tap_pad    out  1       with tap_vld: tap out of image, sorter substitutes 0
//  win_first  out  1       with tap_vld: tap 0 of a window (sorter clears its buffer)
//  win_last   out  1       with tap_vld: tap 8 of a window
//  sort_done  in   1       sorter median valid; honoured only in WAIT
//  sort_data  in   DATA_W  median value, sampled when sort_done=1 in WAIT
//  addr       out  ADDR_W  result RAM write address = current pixel
//  data_wr    out  DATA_W  result RAM write data
//  wen        out  1       result RAM write enable, one-cycle pulse per pixel
//  done       out  1       one-cycle pulse after last pixel written
// BEHAVIOUR
//  Reset: state=IDLE, row=col=0, tap_idx=0. All outputs = 0: busy, iaddr, tap_vld, tap_pad,
//   win_first, win_last, addr, data_wr, wen, done. Reset mid-frame aborts; no further write.
//  FSM: IDLE -(ready)-> FETCH -(tap_idx==8)-> WAIT -(sort_done)-> WRITE
//   WRITE -(pixel!=16383)-> FETCH; WRITE -(pixel==16383)-> FINISH -> IDLE.
//  FETCH: one tap per cycle, tap_idx 0..8 row-major: (dr,dc) = (-1,-1),(-1,0),(-1,+1),
//   (0,-1),(0,0),(0,+1),(+1,-1),(+1,0),(+1,+1).
//   Tap row/col are computed on coordinates, not by address subtraction, so nothing wraps.
//   Pad when row+dr or col+dc is outside 0..127; a padded tap drives iaddr = centre address.
//  tap_vld/tap_pad/win_first/win_last are iaddr-cycle values delayed one register stage,
//   aligned with idata. tap_vld is high 9 consecutive cycles per window.
//  WAIT: hold iaddr and do not advance. The last tap_vld lands in the first WAIT cycle.
//   sort_done in that cycle or any earlier state is ignored. Wait indefinitely otherwise.
//  WRITE: registered outputs in this cycle are wen=1, addr=pixel and data_wr=sort_data as
//   latched in WAIT. Pixel advances col-first; at col=127, col->0 and row+1.
//  Per-pixel latency: 9 FETCH + >=2 WAIT + 1 WRITE = 12 cycles minimum.
//  FINISH: busy->0 and done=1 for one cycle, then IDLE. ready held high restarts the next frame
//   on the cycle after return to IDLE. ready pulses while busy are ignored, not queued.
//  data_wr holds its last value when wen=0. addr is unchanged outside WRITE.
// STRUCTURE
//  Package mfe_pkg: state enum (IDLE, FETCH, WAIT, WRITE, FINISH), TAP_N=9, tap offset
//   tables TAP_DR/TAP_DC, LAST_PIXEL constant.
//  Sub-module mfe_tap_gen (combinational): row, col, tap_idx -> iaddr, pad.
//   Boundary logic is reusable by the sorter bench.
//  Top holds the FSM, row/col/tap counters, the alignment register stage and write registers.
// TESTING
//  1 Reset then ready=1 at pixel (0,0): the 9 taps give pad=1,1,1,1,0,0,1,0,0.
//    iaddr for the non-pad taps is 0,1,128,129; tap_vld starts one cycle after busy rises.
//  2 Pixel (127,127), addr 16383: taps 2,5,6,7,8 are padded, with no iaddr >= 16384.
//    Pixel (0,127): taps 0,1,2,5,8 are padded and iaddr never wraps to row 1 col 0.
//  3 Sorter model asserts sort_done N=1,5,40 cycles after win_last. WRITE follows the first
//    qualifying WAIT cycle and data_wr = model value. sort_done during FETCH has no effect.
//  4 Full frame, sorter returns centre tap: result RAM equals the input image. Exactly 16384
//    wen pulses. done pulses once, 196608 cycles after start at N=1, with busy low after.
//  5 Assert reset at pixel 300 mid-WAIT: next cycle every output is 0 and state is IDLE.
//    A new ready restarts at pixel 0.
//  6 ready toggled while busy causes no restart. ready held high through FINISH starts
//    frame 2 immediately, and frame 2 output matches frame 1.

Source files
------------

// File: rtl/mfe_pkg.sv
// Shared types and constants for the 3x3 median filter scan sequencer.
// Tap tables list the window row-major, from (-1,-1) to (+1,+1).
package mfe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    FINISH
  } state_t;

  localparam int TAP_N = 9;
  localparam int TAP_DR [TAP_N] = '{-1, -1, -1,  0, 0, 0,  1, 1, 1};
  localparam int TAP_DC [TAP_N] = '{-1,  0,  1, -1, 0, 1, -1, 0, 1};

  localparam int LAST_PIXEL = 16383;

endpackage

// File: rtl/mfe_tap_gen.sv
// Maps (row, col, tap index) to an image address and a pad flag.
// Works on signed coordinates so an edge tap never wraps onto a neighbouring row.
module mfe_tap_gen
  import mfe_pkg::*;
#(
  parameter int COL_W  = 7,
  parameter int ROW_W  = 7,
  parameter int ADDR_W = ROW_W + COL_W
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [COL_W-1:0]  col_i,
  input  logic [3:0]        tap_idx_i,
  output logic [ADDR_W-1:0] iaddr_o,
  output logic              pad_o
);

  int idx, tr, tc;

  always_comb begin
    idx = (int'(tap_idx_i) < TAP_N) ? int'(tap_idx_i) : 0;
    tr  = int'(row_i) + TAP_DR[idx];
    tc  = int'(col_i) + TAP_DC[idx];
    pad_o = (tr < 0) || (tr >= (1 << ROW_W)) || (tc < 0) || (tc >= (1 << COL_W));
    // A padded tap still reads a legal location; the sorter ignores its data.
    iaddr_o = pad_o ? {row_i, col_i} : {tr[ROW_W-1:0], tc[COL_W-1:0]};
  end

endmodule

// File: rtl/mfe_scan_ctrl.sv
// Raster-scan sequencer: issues 9 window taps per pixel, waits for the sorter,
// then writes the median to result RAM.
module mfe_scan_ctrl
  import mfe_pkg::*;
#(
  parameter int COL_W  = 7,
  parameter int ROW_W  = 7,
  parameter int ADDR_W = ROW_W + COL_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              tap_vld,
  output logic              tap_pad,
  output logic              win_first,
  output logic              win_last,
  input  logic              sort_done,
  input  logic [DATA_W-1:0] sort_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_wr,
  output logic              wen,
  output logic              done
);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [3:0]          tap_q;
  logic                wfirst_q;
  logic                tap_vld_q, tap_pad_q, win_first_q, win_last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                pad, fetch, last_tap, last_pix;

  mfe_tap_gen #(
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .ADDR_W (ADDR_W)
  ) u_tap (
    .row_i     (row_q),
    .col_i     (col_q),
    .tap_idx_i (tap_q),
    .iaddr_o   (iaddr),
    .pad_o     (pad)
  );

  assign fetch    = (state_q == FETCH);
  assign last_tap = (tap_q == 4'(TAP_N - 1));
  assign last_pix = &{row_q, col_q};

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    wen     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE:   if (ready) state_d = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (last_tap) state_d = WAIT;
      end
      // The first WAIT cycle still carries the last tap, so sort_done there is stale.
      WAIT: begin
        busy = 1'b1;
        if (sort_done && !wfirst_q) state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        wen     = 1'b1;
        state_d = last_pix ? FINISH : FETCH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      tap_q       <= '0;
      wfirst_q    <= 1'b0;
      tap_vld_q   <= 1'b0;
      tap_pad_q   <= 1'b0;
      win_first_q <= 1'b0;
      win_last_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q  <= state_d;
      wfirst_q <= fetch && last_tap;
      if (fetch && !last_tap) tap_q <= tap_q + 4'd1;
      if (state_q == WRITE) begin
        tap_q <= '0;
        col_q <= col_q + 1'b1;
        if (&col_q) row_q <= row_q + 1'b1;
      end
      if (state_q == WAIT && state_d == WRITE) begin
        addr_q <= {row_q, col_q};
        data_q <= sort_data;
      end
      // One stage to line tap flags up with the ROM's registered read data.
      tap_vld_q   <= fetch;
      tap_pad_q   <= fetch && pad;
      win_first_q <= fetch && (tap_q == 4'd0);
      win_last_q  <= fetch && last_tap;
    end
  end

  assign tap_vld   = tap_vld_q;
  assign tap_pad   = tap_pad_q;
  assign win_first = win_first_q;
  assign win_last  = win_last_q;
  assign addr      = addr_q;
  assign data_wr   = data_q;

endmodule

// File: tb/tb_mfe_scan_ctrl.sv
// Bench for mfe_scan_ctrl: full-size DUT for early pixels, reset abort and
// boundary taps; an 8x8 instance for complete frames and back-to-back restart.
module tb_mfe_scan_ctrl;
  import mfe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ready, sort_done;
  logic [7:0]  sort_data, data_wr;
  logic        busy, tap_vld, tap_pad, win_first, win_last, wen, done;
  logic [13:0] iaddr, addr;

  logic        ready_s, sort_done_s;
  logic [7:0]  sort_data_s, data_wr_s, idata_s;
  logic        busy_s, tap_vld_s, tap_pad_s, win_first_s, win_last_s, wen_s, done_s;
  logic [5:0]  iaddr_s, addr_s;

  logic [6:0]  tg_row, tg_col;
  logic [3:0]  tg_tap;
  logic [13:0] tg_addr;
  logic        tg_pad;

  int vec  = 0;
  int errs = 0;

  mfe_scan_ctrl dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
    .tap_vld(tap_vld), .tap_pad(tap_pad), .win_first(win_first), .win_last(win_last),
    .sort_done(sort_done), .sort_data(sort_data), .addr(addr), .data_wr(data_wr),
    .wen(wen), .done(done)
  );

  mfe_scan_ctrl #(.COL_W(3), .ROW_W(3), .ADDR_W(6), .DATA_W(8)) dut_s (
    .clk(clk), .reset(reset), .ready(ready_s), .busy(busy_s), .iaddr(iaddr_s),
    .tap_vld(tap_vld_s), .tap_pad(tap_pad_s), .win_first(win_first_s), .win_last(win_last_s),
    .sort_done(sort_done_s), .sort_data(sort_data_s), .addr(addr_s), .data_wr(data_wr_s),
    .wen(wen_s), .done(done_s)
  );

  mfe_tap_gen #(.COL_W(7), .ROW_W(7), .ADDR_W(14)) u_tg (
    .row_i(tg_row), .col_i(tg_col), .tap_idx_i(tg_tap), .iaddr_o(tg_addr), .pad_o(tg_pad)
  );

  function automatic logic [7:0] img_s(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Image ROM for the small instance: one cycle read latency.
  always_ff @(posedge clk) idata_s <= img_s(int'(iaddr_s));

  // Reference tap: pixel index and tap number -> pad flag and read address (128x128 image).
  function automatic void model_tap(input int p, input int k, output bit pad, output int a);
    int r, c;
    r   = p / 128 + k / 3 - 1;
    c   = p % 128 + k % 3 - 1;
    pad = (r < 0) || (r > 127) || (c < 0) || (c > 127);
    a   = pad ? p : r * 128 + c;
  endfunction

  // Entered on the negedge of the pixel's first FETCH cycle; returns on the negedge after WRITE.
  task automatic do_pixel(input int p, input int n, input bit abort);
    bit pad;
    int a;
    logic [7:0] val;
    val = 8'($urandom);
    for (int k = 0; k < 9; k++) begin
      model_tap(p, k, pad, a);
      vec++;
      if (iaddr !== 14'(a) || busy !== 1'b1 || wen !== 1'b0) begin
        errs++;
        $display("FAIL fetch p=%0d k=%0d: iaddr=%0d busy=%b wen=%b, want iaddr=%0d busy=1 wen=0",
                 p, k, iaddr, busy, wen, a);
      end
      ready     = 1'($urandom_range(0, 1));
      sort_done = 1'($urandom_range(0, 1));
      sort_data = 8'($urandom);
      @(negedge clk);
      vec++;
      if ({tap_vld, tap_pad, win_first, win_last} !== {1'b1, pad, k == 0, k == 8}) begin
        errs++;
        $display("FAIL tapflags p=%0d k=%0d: vld/pad/first/last=%b, want %b",
                 p, k, {tap_vld, tap_pad, win_first, win_last}, {1'b1, pad, k == 0, k == 8});
      end
    end
    sort_done = 1'($urandom_range(0, 1));
    sort_data = 8'($urandom);
    if (abort) begin
      ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      sort_done = 1'b0;
      vec++;
      if ({busy, iaddr, tap_vld, tap_pad, win_first, win_last, addr, data_wr, wen, done} !== '0) begin
        errs++;
        $display("FAIL abort: busy=%b iaddr=%0d tap=%b addr=%0d data_wr=%0d wen=%b done=%b, want all 0",
                 busy, iaddr, {tap_vld, tap_pad, win_first, win_last}, addr, data_wr, wen, done);
      end
      repeat (4) begin
        @(negedge clk);
        vec++;
        if (busy !== 1'b0 || wen !== 1'b0 || tap_vld !== 1'b0) begin
          errs++;
          $display("FAIL abort_idle: busy=%b wen=%b tap_vld=%b, want 0 0 0", busy, wen, tap_vld);
        end
      end
      return;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      vec++;
      if (wen !== 1'b0 || tap_vld !== 1'b0 || iaddr !== 14'(a) || busy !== 1'b1) begin
        errs++;
        $display("FAIL wait p=%0d i=%0d: wen=%b tap_vld=%b iaddr=%0d busy=%b, want 0 0 %0d 1",
                 p, i, wen, tap_vld, iaddr, busy, a);
      end
      ready = 1'($urandom_range(0, 1));
      if (i < n) sort_done = 1'b0;
      else begin
        sort_done = 1'b1;
        sort_data = val;
      end
    end
    @(negedge clk);
    vec++;
    if (wen !== 1'b1 || addr !== 14'(p) || data_wr !== val || busy !== 1'b1) begin
      errs++;
      $display("FAIL write p=%0d: wen=%b addr=%0d data_wr=%0d busy=%b, want 1 %0d %0d 1",
               p, wen, addr, data_wr, busy, p, val);
    end
    sort_done = 1'b0;
    sort_data = 8'($urandom);
    @(negedge clk);
    vec++;
    if (wen !== 1'b0 || addr !== 14'(p) || data_wr !== val) begin
      errs++;
      $display("FAIL hold p=%0d: wen=%b addr=%0d data_wr=%0d, want 0 %0d %0d",
               p, wen, addr, data_wr, p, val);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ready = 1'b1; sort_done = 1'b1; sort_data = 8'hA5;
    ready_s = 1'b1; sort_done_s = 1'b0; sort_data_s = 8'h00;
    repeat (3) @(negedge clk);
    vec++;
    if ({busy, iaddr, tap_vld, tap_pad, win_first, win_last, addr, data_wr, wen, done} !== '0) begin
      errs++;
      $display("FAIL reset: busy=%b iaddr=%0d tap=%b addr=%0d data_wr=%0d wen=%b done=%b, want all 0",
               busy, iaddr, {tap_vld, tap_pad, win_first, win_last}, addr, data_wr, wen, done);
    end
    vec++;
    if ({busy_s, iaddr_s, tap_vld_s, addr_s, data_wr_s, wen_s, done_s} !== '0) begin
      errs++;
      $display("FAIL reset_small: busy=%b iaddr=%0d addr=%0d wen=%b done=%b, want all 0",
               busy_s, iaddr_s, addr_s, wen_s, done_s);
    end
    reset = 1'b0; ready = 1'b0; ready_s = 1'b0; sort_done = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if (busy !== 1'b0 || busy_s !== 1'b0) begin
      errs++;
      $display("FAIL idle_hold: busy=%b busy_s=%b, want 0 0", busy, busy_s);
    end
  endtask

  task automatic start_frame();
    ready = 1'b1;
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL start_idle: busy=%b, want 0", busy);
    end
    @(negedge clk);
    vec++;
    if (busy !== 1'b1 || tap_vld !== 1'b0) begin
      errs++;
      $display("FAIL start: busy=%b tap_vld=%b, want 1 0", busy, tap_vld);
    end
  endtask

  task automatic test_first_pixel();
    start_frame();
    do_pixel(0, 1, 1'b0);
  endtask

  task automatic test_sort_latency();
    int r, n;
    for (int p = 1; p < 300; p++) begin
      r = $urandom_range(0, 2);
      n = (r == 0) ? 1 : (r == 1) ? 5 : 40;
      do_pixel(p, n, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_pixel(300, 1, 1'b1);
    start_frame();
    do_pixel(0, 1, 1'b0);
    do_pixel(1, 5, 1'b0);
    ready = 1'b0;
  endtask

  task automatic test_tap_bounds();
    int plist [6];
    int p, a;
    bit pad;
    plist = '{LAST_PIXEL, 127, 16256, 0, 8191, 200};
    for (int i = 0; i < 16; i++) begin
      if (i < 6) p = plist[i];
      else p = $urandom_range(0, LAST_PIXEL);
      for (int k = 0; k < 9; k++) begin
        tg_row = 7'(p / 128);
        tg_col = 7'(p % 128);
        tg_tap = 4'(k);
        #1;
        model_tap(p, k, pad, a);
        vec++;
        if (tg_pad !== pad || tg_addr !== 14'(a)) begin
          errs++;
          $display("FAIL tapgen p=%0d k=%0d: pad=%b iaddr=%0d, want %b %0d", p, k, tg_pad, tg_addr, pad, a);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res [2][64];
    int frames, t_start, t_done, wens, tapn;
    bit pend, busy_prev;
    logic [7:0] centre;
    frames = 0; t_start = -1000; t_done = -1000; wens = 0; tapn = 0;
    pend = 1'b0; busy_prev = 1'b0; centre = 8'h00;
    for (int f = 0; f < 2; f++) for (int a = 0; a < 64; a++) res[f][a] = 8'hxx;
    ready_s = 1'b1;
    for (int cyc = 0; cyc < 4000 && frames < 2; cyc++) begin
      @(negedge clk);
      if (busy_s && !busy_prev) begin
        if (frames == 1) begin
          vec++;
          if (cyc != t_done + 2) begin
            errs++;
            $display("FAIL restart: frame 2 busy at +%0d after done, want +2", cyc - t_done);
          end
        end
        t_start = cyc;
      end
      busy_prev = busy_s;
      if (tap_vld_s) begin
        if (win_first_s) tapn = 0;
        if (tapn == 4) centre = idata_s;
        tapn++;
      end
      // Sorter returns the centre tap one cycle after win_last.
      sort_done_s = pend;
      sort_data_s = centre;
      pend = win_last_s;
      if (wen_s) begin
        res[frames][addr_s] = data_wr_s;
        wens++;
      end
      if (done_s) begin
        vec++;
        if (cyc - t_start != 768) begin
          errs++;
          $display("FAIL frame_len f=%0d: done %0d cycles after start, want 768", frames, cyc - t_start);
        end
        vec++;
        if (wens != 64 * (frames + 1)) begin
          errs++;
          $display("FAIL wen_count f=%0d: %0d pulses, want %0d", frames, wens, 64 * (frames + 1));
        end
        t_done = cyc;
        frames++;
        if (frames == 2) ready_s = 1'b0;
      end
    end
    vec++;
    if (frames != 2) begin
      errs++;
      $display("FAIL frames: %0d completed in budget, want 2", frames);
    end
    ready_s = 1'b0;
    sort_done_s = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || wen_s !== 1'b0) begin
      errs++;
      $display("FAIL after_frame: busy=%b done=%b wen=%b, want 0 0 0", busy_s, done_s, wen_s);
    end
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 64; a++) begin
        vec++;
        if (res[f][a] !== img_s(a)) begin
          errs++;
          $display("FAIL result f=%0d a=%0d: got %h, want %h", f, a, res[f][a], img_s(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_sort_latency();
    test_reset_mid();
    test_back_to_back();
    test_tap_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
